// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared timing definitions for the VGA raster generator.
//   - Default 640x480 @ 60 Hz timing constants (pixels / lines).
//   - Helper functions that derive axis totals and sync window bounds, so the
//     top level and the axis counters agree on one definition of each.
//   - Coordinate width (10 bits) and the matching coordinate type.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Raster coordinates are 10-bit unsigned; any axis must fit in 0..1023.
  localparam int COORD_W         = 10;
  localparam int COORD_MAX_TOTAL = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  // Axis total: visible + front porch + sync + back porch.
  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  // First position inside the sync pulse.
  function automatic int sync_start(input int active, input int front);
    return active + front;
  endfunction

  // First position after the sync pulse (exclusive bound).
  function automatic int sync_end(input int active, input int front,
                                  input int sync);
    return active + front + sync;
  endfunction

  // Default horizontal timing, in pixels.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default vertical timing, in lines.
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Both syncs are active-low in the standard 640x480 mode.
  localparam bit DEF_HS_POL = 1'b0;
  localparam bit DEF_VS_POL = 1'b0;

  // Derived defaults (800 x 525, sync windows 656..751 and 490..491).
  localparam int DEF_H_TOTAL      = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL      = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int DEF_H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
  localparam int DEF_H_SYNC_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam int DEF_V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
  localparam int DEF_V_SYNC_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//
// One raster axis (horizontal or vertical). Holds the position counter and
// decodes the sync window and visible region for the position the counter
// is about to take, so the parent can register those flags alongside the
// counter and keep every output aligned to the same pixel.
//
// Parameters:
//   ACTIVE, FRONT, SYNC, BACK - axis timing (pixels or lines)
//   POL                       - asserted level of the sync output
// Ports:
//   CLK    in   clock
//   RST    in   synchronous active-high reset (counter -> 0)
//   en     in   advance the counter this clock
//   count  out  current position (registered), 0..TOTAL-1
//   wrap   out  this clock takes the counter from TOTAL-1 back to 0
//   sync   out  sync level for the next position (POL when inside window)
//   active out  next position lies in the visible region
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BP,
  parameter bit POL    = DEF_HS_POL
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   en,
  output coord_t count,
  output logic   wrap,
  output logic   sync,
  output logic   active
);

  localparam int     TOTAL    = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam int     S_START  = sync_start(ACTIVE, FRONT);
  localparam int     S_END    = sync_end(ACTIVE, FRONT, SYNC);
  localparam coord_t LAST_POS = coord_t'(TOTAL - 1);

  coord_t count_next;
  int     next_pos;

  // Reset is folded into the next-state value so the decoded flags below
  // describe exactly what the counter will hold after this clock.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    wrap       = 1'b0;
    count_next = count;

    if (en && (count == LAST_POS)) begin
      wrap = 1'b1;
    end

    if (RST) begin
      count_next = '0;
    end else if (wrap) begin
      count_next = '0;
    end else if (en) begin
      count_next = count + coord_t'(1);
    end

    next_pos = int'(count_next);
    sync     = ((next_pos >= S_START) && (next_pos < S_END)) ? POL : ~POL;
    active   = (next_pos < ACTIVE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge CLK) begin
    count <= count_next;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// Raster timing generator for VGA output (640x480 @ 60 Hz by default), run
// on the pixel clock. A horizontal axis counter advances every clock; its
// wrap enables the vertical axis counter, so y (and therefore VS) only
// changes on the clock where x returns to 0.
//
// HS, VS and blank are registered from the counters' next-state decode, so
// in any cycle they describe the same pixel as x/y (zero relative latency).
//
// Ports:
//   CLK   in   pixel clock
//   RST   in   synchronous active-high reset -> (0,0), syncs deasserted
//   HS    out  horizontal sync, HS_POL when asserted
//   VS    out  vertical sync, VS_POL when asserted (whole-line quantity)
//   x     out  horizontal position 0..H_TOTAL-1 (raw, not clamped)
//   y     out  vertical position 0..V_TOTAL-1 (raw, not clamped)
//   blank out  1 when (x,y) lies outside the visible area
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               HS,
  output logic               VS,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               blank
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Counters are 10-bit; a larger raster would silently alias.
  if (H_TOTAL > COORD_MAX_TOTAL) begin : g_h_total_check
    $error("vga_sync_gen: H_TOTAL exceeds the 10-bit coordinate range");
  end
  if (V_TOTAL > COORD_MAX_TOTAL) begin : g_v_total_check
    $error("vga_sync_gen: V_TOTAL exceeds the 10-bit coordinate range");
  end

  coord_t h_count;
  coord_t v_count;
  logic   h_wrap;
  logic   v_wrap;
  logic   h_sync;
  logic   v_sync;
  logic   h_active;
  logic   v_active;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FP),
    .SYNC   (H_SYNC),
    .BACK   (H_BP),
    .POL    (HS_POL)
  ) u_h_axis (
    .CLK    (CLK),
    .RST    (RST),
    .en     (1'b1),
    .count  (h_count),
    .wrap   (h_wrap),
    .sync   (h_sync),
    .active (h_active)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FP),
    .SYNC   (V_SYNC),
    .BACK   (V_BP),
    .POL    (VS_POL)
  ) u_v_axis (
    .CLK    (CLK),
    .RST    (RST),
    .en     (h_wrap),
    .count  (v_count),
    .wrap   (v_wrap),
    .sync   (v_sync),
    .active (v_active)
  );

  // The counters themselves are the x/y flops.
  assign x = h_count;
  assign y = v_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      HS    <= ~HS_POL;
      VS    <= ~VS_POL;
      blank <= 1'b0;
    end else begin
      HS    <= h_sync;
      VS    <= v_sync;
      blank <= ~(h_active & v_active);
    end
  end

  // The vertical axis can only wrap on a clock where the horizontal one does.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!v_wrap || h_wrap);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Two instances share one pixel clock: the default 640x480 timing and a tiny
// override raster (14 x 7) that makes whole frames cheap. Each clock the
// bench advances its own position model for both, pushes the expected
// outputs into per-instance queues, then pops and compares after the edge.
// Edge-to-edge intervals (sync widths, line and frame periods) are measured
// from the sampled outputs and checked against the timing totals.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    bit hp; bit vp;
  } cfg_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
  } smp_t;

  localparam cfg_t CFG_D = '{ha: 640, hf: 16, hs: 96, hb: 48,
                             va: 480, vf: 10, vs: 2,  vb: 33,
                             hp: 1'b0, vp: 1'b0};
  localparam cfg_t CFG_S = '{ha: 8, hf: 2, hs: 3, hb: 1,
                             va: 4, vf: 1, vs: 1, vb: 1,
                             hp: 1'b1, vp: 1'b0};

  logic       CLK = 1'b0;
  logic       rst_d;
  logic       rst_s;
  logic       hs_d, vs_d, blank_d;
  logic       hs_s, vs_s, blank_s;
  logic [9:0] x_d, y_d, x_s, y_s;

  vga_sync_gen dut_d (
    .CLK   (CLK),
    .RST   (rst_d),
    .HS    (hs_d),
    .VS    (vs_d),
    .x     (x_d),
    .y     (y_d),
    .blank (blank_d)
  );

  vga_sync_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (1'b1), .VS_POL (1'b0)
  ) dut_s (
    .CLK   (CLK),
    .RST   (rst_s),
    .HS    (hs_s),
    .VS    (vs_s),
    .x     (x_s),
    .y     (y_s),
    .blank (blank_s)
  );

  always #5 CLK = ~CLK;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  smp_t q_d[$];
  smp_t q_s[$];
  int   md_x = 0, md_y = 0, ms_x = 0, ms_y = 0;

  // Measurements on the default instance (HS active-low).
  logic d_hs_prev = 1'b1, d_blank_prev = 1'b0;
  int   d_hs_low = 0, d_hs_low_len = -1, d_fall_t = -1, d_line_period = -1;
  int   d_blank_rise_x = -1;
  // Measurements on the small instance (HS active-high, VS active-low).
  logic s_hs_prev = 1'b0, s_vs_prev = 1'b1;
  int   s_hs_high = 0, s_hs_high_len = -1, s_hs_rise_t = -1, s_line_period = -1;
  int   s_vs_low = 0, s_vs_low_len = -1, s_vs_rise_t = -1, s_frame_period = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic smp_t expect_at(input int px, input int py, input cfg_t c, input bit r);
    smp_t e;
    bit   hs_on, vs_on;
    hs_on   = (px >= c.ha + c.hf) && (px < c.ha + c.hf + c.hs);
    vs_on   = (py >= c.va + c.vf) && (py < c.va + c.vf + c.vs);
    e.x     = 10'(px);
    e.y     = 10'(py);
    e.hs    = (hs_on && !r) ? c.hp : ~c.hp;
    e.vs    = (vs_on && !r) ? c.vp : ~c.vp;
    e.blank = !r && ((px >= c.ha) || (py >= c.va));
    return e;
  endfunction

  task automatic advance(inout int px, inout int py, input cfg_t c, input bit r);
    int htot, vtot;
    htot = c.ha + c.hf + c.hs + c.hb;
    vtot = c.va + c.vf + c.vs + c.vb;
    if (r) begin
      px = 0;
      py = 0;
    end else if (px == htot - 1) begin
      px = 0;
      py = (py == vtot - 1) ? 0 : py + 1;
    end else begin
      px = px + 1;
    end
  endtask

  task automatic compare(input string pfx, input smp_t obs, input smp_t e);
    check($sformatf("%s.x@%0d", pfx, cyc),     32'(obs.x),     32'(e.x));
    check($sformatf("%s.y@%0d", pfx, cyc),     32'(obs.y),     32'(e.y));
    check($sformatf("%s.HS@%0d", pfx, cyc),    32'(obs.hs),    32'(e.hs));
    check($sformatf("%s.VS@%0d", pfx, cyc),    32'(obs.vs),    32'(e.vs));
    check($sformatf("%s.blank@%0d", pfx, cyc), 32'(obs.blank), 32'(e.blank));
  endtask

  // One pixel clock: drive resets, queue expectations, sample after the edge.
  task automatic tick(input bit rd, input bit rs);
    smp_t od, os;
    rst_d = rd;
    rst_s = rs;
    advance(md_x, md_y, CFG_D, rd);
    q_d.push_back(expect_at(md_x, md_y, CFG_D, rd));
    advance(ms_x, ms_y, CFG_S, rs);
    q_s.push_back(expect_at(ms_x, ms_y, CFG_S, rs));
    @(posedge CLK);
    #1;
    cyc++;
    od = '{x: x_d, y: y_d, hs: hs_d, vs: vs_d, blank: blank_d};
    os = '{x: x_s, y: y_s, hs: hs_s, vs: vs_s, blank: blank_s};
    compare("dflt", od, q_d.pop_front());
    compare("small", os, q_s.pop_front());

    if (rd) begin
      d_hs_prev = 1'b1; d_hs_low = 0; d_fall_t = -1; d_blank_prev = 1'b0;
    end else begin
      if (hs_d === 1'b0) d_hs_low++;
      if (d_hs_prev === 1'b1 && hs_d === 1'b0) begin
        if (d_fall_t >= 0) d_line_period = cyc - d_fall_t;
        d_fall_t = cyc;
      end
      if (d_hs_prev === 1'b0 && hs_d === 1'b1) begin
        d_hs_low_len = d_hs_low;
        d_hs_low     = 0;
      end
      if (d_blank_prev === 1'b0 && blank_d === 1'b1 && y_d < 10'd480) d_blank_rise_x = int'(x_d);
      d_hs_prev    = hs_d;
      d_blank_prev = blank_d;
    end

    if (rs) begin
      s_hs_prev = 1'b0; s_hs_high = 0; s_hs_rise_t = -1;
      s_vs_prev = 1'b1; s_vs_low = 0;  s_vs_rise_t = -1;
    end else begin
      if (hs_s === 1'b1) s_hs_high++;
      if (s_hs_prev === 1'b0 && hs_s === 1'b1) begin
        if (s_hs_rise_t >= 0) s_line_period = cyc - s_hs_rise_t;
        s_hs_rise_t = cyc;
      end
      if (s_hs_prev === 1'b1 && hs_s === 1'b0) begin
        s_hs_high_len = s_hs_high;
        s_hs_high     = 0;
      end
      if (vs_s === 1'b0) s_vs_low++;
      if (s_vs_prev === 1'b0 && vs_s === 1'b1) begin
        s_vs_low_len = s_vs_low;
        s_vs_low     = 0;
        if (s_vs_rise_t >= 0) s_frame_period = cyc - s_vs_rise_t;
        s_vs_rise_t = cyc;
      end
      s_hs_prev = hs_s;
      s_vs_prev = vs_s;
    end
  endtask

  initial begin
    rst_d = 1'b1;
    rst_s = 1'b1;

    // Power-up reset held for three clocks, then free-running counting.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 2400; i++) tick(1'b0, 1'b0);

    check("dflt.hs_low_width",   32'(d_hs_low_len),   32'(96));
    check("dflt.line_period",    32'(d_line_period),  32'(800));
    check("dflt.blank_rise_x",   32'(d_blank_rise_x), 32'(640));
    check("small.hs_high_width", 32'(s_hs_high_len),  32'(3));
    check("small.line_period",   32'(s_line_period),  32'(14));
    check("small.vs_low_width",  32'(s_vs_low_len),   32'(14));
    check("small.frame_period",  32'(s_frame_period), 32'(98));

    // Mid-frame reset of the small raster at (5,2).
    for (int i = 0; i < 200 && !(ms_x == 5 && ms_y == 2); i++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);

    // Mid-frame reset of the default raster at x=300.
    for (int i = 0; i < 1000 && md_x != 300; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);

    d_hs_low_len   = -1;
    d_line_period  = -1;
    s_vs_low_len   = -1;
    s_frame_period = -1;
    for (int i = 0; i < 1600; i++) tick(1'b0, 1'b0);

    check("dflt.hs_low_width_after_rst",   32'(d_hs_low_len),   32'(96));
    check("dflt.line_period_after_rst",    32'(d_line_period),  32'(800));
    check("small.vs_low_width_after_rst",  32'(s_vs_low_len),   32'(14));
    check("small.frame_period_after_rst",  32'(s_frame_period), 32'(98));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
